// File: rtl/stream_mux2_if.sv
// Handshake bundle for the 2-to-1 packet mux: two valid/ready/last input streams and one output stream.
// The slave modport is the mux side; the master modport is the traffic source/sink side.
interface stream_mux2_if #(
  parameter int WIDTH = 8
);
  logic             in1_valid;
  logic [WIDTH-1:0] in1_data;
  logic             in1_last;
  logic             in1_ready;
  logic             in2_valid;
  logic [WIDTH-1:0] in2_data;
  logic             in2_last;
  logic             in2_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_last;
  logic             out_src;
  logic             out_ready;
  logic [1:0]       dbg_state;

  modport slave (
    input  in1_valid, in1_data, in1_last,
    input  in2_valid, in2_data, in2_last,
    input  out_ready,
    output in1_ready, in2_ready,
    output out_valid, out_data, out_last, out_src,
    output dbg_state
  );

  modport master (
    output in1_valid, in1_data, in1_last,
    output in2_valid, in2_data, in2_last,
    output out_ready,
    input  in1_ready, in2_ready,
    input  out_valid, out_data, out_last, out_src,
    input  dbg_state
  );
endinterface

// File: rtl/stream_mux2.sv
// Two-input packet mux with round-robin packet arbitration, lock-until-last, and a single
// registered output stage that sustains one beat per cycle.
module stream_mux2 #(
  parameter int WIDTH = 8
) (
  input  logic         clk,
  input  logic         reset,
  stream_mux2_if.slave bus
);
  // Handshake: a beat moves on a port when valid and ready are both high at a rising clk edge.
  // Readys are combinational; valids must never depend on them.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK1 = 2'd1,
    LOCK2 = 2'd2
  } state_t;

  state_t           state, state_next;
  logic             ptr, ptr_next;  // input that wins a tie: 0 = in1, 1 = in2
  logic             space;
  logic             rdy1, rdy2;
  logic             acc1, acc2;
  logic             out_valid_q;
  logic [WIDTH-1:0] out_data_q;
  logic             out_last_q;
  logic             out_src_q;

  // Register can take a beat when empty or when its current beat leaves this cycle.
  assign space = !out_valid_q || bus.out_ready;
  assign acc1  = rdy1 && bus.in1_valid;
  assign acc2  = rdy2 && bus.in2_valid;

  always_comb begin
    rdy1       = 1'b0;
    rdy2       = 1'b0;
    state_next = state;
    ptr_next   = ptr;
    case (state)
      IDLE: begin
        if (bus.in1_valid && (!bus.in2_valid || !ptr)) rdy1 = space;
        else if (bus.in2_valid)                         rdy2 = space;
      end
      LOCK1:   rdy1 = space;
      LOCK2:   rdy2 = space;
      default: state_next = IDLE;
    endcase
    if (rdy1 && bus.in1_valid) begin
      if (bus.in1_last) begin
        state_next = IDLE;
        ptr_next   = 1'b1;
      end else begin
        state_next = LOCK1;
      end
    end else if (rdy2 && bus.in2_valid) begin
      if (bus.in2_last) begin
        state_next = IDLE;
        ptr_next   = 1'b0;
      end else begin
        state_next = LOCK2;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      ptr   <= 1'b0;
    end else begin
      state <= state_next;
      ptr   <= ptr_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_src_q   <= 1'b0;
    end else if (acc1) begin
      out_valid_q <= 1'b1;
      out_data_q  <= bus.in1_data;
      out_last_q  <= bus.in1_last;
      out_src_q   <= 1'b0;
    end else if (acc2) begin
      out_valid_q <= 1'b1;
      out_data_q  <= bus.in2_data;
      out_last_q  <= bus.in2_last;
      out_src_q   <= 1'b1;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.in1_ready = rdy1;
  assign bus.in2_ready = rdy2;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_src   = out_src_q;
  assign bus.dbg_state = state;
endmodule

// File: tb/tb_stream_mux2.sv
// Self-checking bench for stream_mux2: arbitration vector table, directed multi-cycle
// sequences, and a long randomized run against a packet-level reference model.
module tb_stream_mux2;
  localparam int WIDTH = 8;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_bad;

  stream_mux2_if #(.WIDTH(WIDTH)) bus ();

  stream_mux2 #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model state ----------------
  logic [WIDTH:0] exp_q1[$];
  logic [WIDTH:0] exp_q2[$];
  bit             m_occ;       // output register holds a beat
  bit             m_pkt_open;  // an input packet is partly accepted
  bit             m_pkt_src;
  bit             m_rr;        // input that wins the next tie
  bit             m_out_open;  // an output packet is partly delivered
  bit             m_out_cur;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    reset         = 1'b1;
    bus.in1_valid = 1'b0;
    bus.in1_data  = '0;
    bus.in1_last  = 1'b0;
    bus.in2_valid = 1'b0;
    bus.in2_data  = '0;
    bus.in2_last  = 1'b0;
    bus.out_ready = 1'b1;
    step();
    step();
    reset = 1'b0;
    exp_q1.delete();
    exp_q2.delete();
    m_occ      = 1'b0;
    m_pkt_open = 1'b0;
    m_pkt_src  = 1'b0;
    m_rr       = 1'b0;
    m_out_open = 1'b0;
    m_out_cur  = 1'b0;
  endtask

  task automatic drive1(input bit v, input logic [WIDTH-1:0] d, input bit l);
    bus.in1_valid = v;
    bus.in1_data  = d;
    bus.in1_last  = l;
  endtask

  task automatic drive2(input bit v, input logic [WIDTH-1:0] d, input bit l);
    bus.in2_valid = v;
    bus.in2_data  = d;
    bus.in2_last  = l;
  endtask

  task automatic chk_out(input string name, input logic [WIDTH-1:0] d, input bit l, input bit s);
    chk({name, "_valid"}, 32'(bus.out_valid), 32'(1'b1));
    chk({name, "_data"},  32'(bus.out_data),  32'(d));
    chk({name, "_last"},  32'(bus.out_last),  32'(l));
    chk({name, "_src"},   32'(bus.out_src),   32'(s));
  endtask

  task automatic chk_rdy(input string name, input bit r1, input bit r2);
    chk({name, "_in1_ready"}, 32'(bus.in1_ready), 32'(r1));
    chk({name, "_in2_ready"}, 32'(bus.in2_ready), 32'(r2));
  endtask

  // One randomized cycle: predict readys from the arbitration rules, score output beats
  // per source, then advance the model across the clock edge.
  task automatic rnd_cycle(input bit quiet);
    bit             sp, e1, e2, a1, a2;
    logic [WIDTH:0] beat;
    if (quiet) begin
      drive1(1'b0, '0, 1'b0);
      drive2(1'b0, '0, 1'b0);
      bus.out_ready = 1'b1;
    end else begin
      drive1($urandom_range(0, 9) < 6, WIDTH'($urandom_range(0, 255)), $urandom_range(0, 3) == 0);
      drive2($urandom_range(0, 9) < 6, WIDTH'($urandom_range(0, 255)), $urandom_range(0, 3) == 0);
      bus.out_ready = ($urandom_range(0, 9) < 7);
    end
    #1;
    sp = !m_occ || bus.out_ready;
    e1 = 1'b0;
    e2 = 1'b0;
    if (sp) begin
      if (m_pkt_open)                       begin e1 = !m_pkt_src; e2 = m_pkt_src; end
      else if (bus.in1_valid && bus.in2_valid) begin e1 = !m_rr; e2 = m_rr; end
      else if (bus.in1_valid)               e1 = 1'b1;
      else if (bus.in2_valid)               e2 = 1'b1;
    end
    chk("rnd_out_valid", 32'(bus.out_valid), 32'(m_occ));
    chk_rdy("rnd", e1, e2);
    if (m_occ && bus.out_ready) begin
      if (m_out_open) chk("rnd_no_interleave", 32'(bus.out_src), 32'(m_out_cur));
      if (bus.out_src == 1'b0) begin
        if (exp_q1.size() == 0) chk("rnd_src1_underflow", 32'(1), 32'(0));
        else begin
          beat = exp_q1.pop_front();
          chk("rnd_src1_beat", 32'({bus.out_last, bus.out_data}), 32'(beat));
        end
      end else begin
        if (exp_q2.size() == 0) chk("rnd_src2_underflow", 32'(1), 32'(0));
        else begin
          beat = exp_q2.pop_front();
          chk("rnd_src2_beat", 32'({bus.out_last, bus.out_data}), 32'(beat));
        end
      end
      m_out_open = !bus.out_last;
      m_out_cur  = bus.out_src;
    end
    a1 = e1 && bus.in1_valid;
    a2 = e2 && bus.in2_valid;
    if (a1) exp_q1.push_back({bus.in1_last, bus.in1_data});
    if (a2) exp_q2.push_back({bus.in2_last, bus.in2_data});
    if (a1 || a2) begin
      if ((a1 && bus.in1_last) || (a2 && bus.in2_last)) begin
        m_pkt_open = 1'b0;
        m_rr       = a1;
      end else begin
        m_pkt_open = 1'b1;
        m_pkt_src  = a2;
      end
    end
    m_occ = (a1 || a2) ? 1'b1 : (m_occ && !bus.out_ready);
    step();
  endtask

  // ---------------- arbitration vector table ----------------
  typedef struct {
    bit ptr2;  // tie pointer moved to in2 by a prior in1 packet
    bit v1;
    bit v2;
    bit r1;
    bit r2;
  } arb_vec_t;

  arb_vec_t vecs[8];

  initial begin
    n_cmp = 0;
    n_bad = 0;
    vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[3] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

    // reset state
    do_reset();
    chk("reset_out_valid", 32'(bus.out_valid), 32'(0));
    chk("reset_out_data",  32'(bus.out_data),  32'(0));
    chk("reset_out_last",  32'(bus.out_last),  32'(0));
    chk("reset_out_src",   32'(bus.out_src),   32'(0));
    #1;
    chk_rdy("reset", 1'b0, 1'b0);

    for (int i = 0; i < 8; i++) begin
      do_reset();
      if (vecs[i].ptr2) begin
        drive1(1'b1, 8'h5A, 1'b1);
        step();
        drive1(1'b0, '0, 1'b0);
      end
      drive1(vecs[i].v1, 8'h10 + 8'(i), 1'b1);
      drive2(vecs[i].v2, 8'h20 + 8'(i), 1'b1);
      #1;
      chk_rdy($sformatf("vec%0d", i), vecs[i].r1, vecs[i].r2);
    end

    // single beat, latency 1
    do_reset();
    drive1(1'b1, 8'hA1, 1'b1);
    #1;
    chk_rdy("t1_accept", 1'b1, 1'b0);
    step();
    drive1(1'b0, '0, 1'b0);
    chk_out("t1_out", 8'hA1, 1'b1, 1'b0);
    step();
    chk("t1_empty", 32'(bus.out_valid), 32'(0));

    // round robin between single-beat packets, one beat per cycle
    do_reset();
    drive1(1'b1, 8'h11, 1'b1);
    drive2(1'b1, 8'h21, 1'b1);
    #1; chk_rdy("t2_c0", 1'b1, 1'b0);
    step();
    drive1(1'b1, 8'h12, 1'b1);
    #1; chk_out("t2_o0", 8'h11, 1'b1, 1'b0); chk_rdy("t2_c1", 1'b0, 1'b1);
    step();
    drive2(1'b1, 8'h22, 1'b1);
    #1; chk_out("t2_o1", 8'h21, 1'b1, 1'b1); chk_rdy("t2_c2", 1'b1, 1'b0);
    step();
    drive1(1'b0, '0, 1'b0);
    #1; chk_out("t2_o2", 8'h12, 1'b1, 1'b0); chk_rdy("t2_c3", 1'b0, 1'b1);
    step();
    drive2(1'b0, '0, 1'b0);
    chk_out("t2_o3", 8'h22, 1'b1, 1'b1);
    step();
    chk("t2_empty", 32'(bus.out_valid), 32'(0));

    // multi-beat lock holds off the other input
    do_reset();
    drive1(1'b1, 8'h31, 1'b0);
    drive2(1'b1, 8'h51, 1'b1);
    #1; chk_rdy("t3_b0", 1'b1, 1'b0);
    step();
    drive1(1'b1, 8'h32, 1'b0);
    #1; chk_rdy("t3_b1", 1'b1, 1'b0); chk_out("t3_o0", 8'h31, 1'b0, 1'b0);
    step();
    drive1(1'b1, 8'h33, 1'b1);
    #1; chk_rdy("t3_b2", 1'b1, 1'b0); chk_out("t3_o1", 8'h32, 1'b0, 1'b0);
    step();
    drive1(1'b0, '0, 1'b0);
    #1; chk_rdy("t3_in2_grant", 1'b0, 1'b1); chk_out("t3_o2", 8'h33, 1'b1, 1'b0);
    step();
    drive2(1'b0, '0, 1'b0);
    chk_out("t3_o3", 8'h51, 1'b1, 1'b1);

    // backpressure holds the output beat and both readys
    do_reset();
    bus.out_ready = 1'b0;
    drive1(1'b1, 8'h44, 1'b1);
    #1; chk_rdy("t4_first", 1'b1, 1'b0);
    step();
    drive1(1'b1, 8'h45, 1'b1);
    drive2(1'b1, 8'h46, 1'b1);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk_out($sformatf("t4_hold%0d", i), 8'h44, 1'b1, 1'b0);
      chk_rdy($sformatf("t4_stall%0d", i), 1'b0, 1'b0);
      step();
    end
    bus.out_ready = 1'b1;
    #1; chk_out("t4_release", 8'h44, 1'b1, 1'b0); chk_rdy("t4_resume", 1'b0, 1'b1);
    step();
    drive2(1'b0, '0, 1'b0);
    #1; chk_out("t4_o1", 8'h46, 1'b1, 1'b1); chk_rdy("t4_next", 1'b1, 1'b0);
    step();
    drive1(1'b0, '0, 1'b0);
    chk_out("t4_o2", 8'h45, 1'b1, 1'b0);

    // reset in the middle of a locked packet
    do_reset();
    drive1(1'b1, 8'h61, 1'b0);
    drive2(1'b1, 8'h71, 1'b1);
    step();
    #1; chk_rdy("t5_locked", 1'b1, 1'b0);
    drive2(1'b0, '0, 1'b0);
    #1; chk_rdy("t5_locked_only2", 1'b1, 1'b0);
    drive2(1'b1, 8'h71, 1'b1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("t5_out_valid", 32'(bus.out_valid), 32'(0));
    chk("t5_out_data",  32'(bus.out_data),  32'(0));
    #1; chk_rdy("t5_both", 1'b1, 1'b0);
    drive1(1'b0, '0, 1'b0);
    #1; chk_rdy("t5_in2_only", 1'b0, 1'b1);

    // randomized run against the reference model
    do_reset();
    for (int c = 0; c < 10000; c++) rnd_cycle(1'b0);
    for (int c = 0; c < 4; c++) rnd_cycle(1'b1);
    chk("rnd_q1_drained", 32'(exp_q1.size()), 32'(0));
    chk("rnd_q2_drained", 32'(exp_q2.size()), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
